// File: rtl/mult_pkg.sv
// Shared defaults and FSM state encoding for the multiplier issue controller.
package mult_pkg;

    localparam int unsigned DEF_LENGTH  = 32;
    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned DEF_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } state_e;

endpackage

// File: rtl/mult_issue_ctrl_if.sv
// Operand input, multiplier and product output handshakes of the issue controller.
interface mult_issue_ctrl_if #(
    parameter int unsigned LENGTH = mult_pkg::DEF_LENGTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [LENGTH-1:0]     in_a;
    logic [LENGTH-1:0]     in_b;
    logic                  mul_start;
    logic                  mul_ready;
    logic [LENGTH-1:0]     mul_a;
    logic [LENGTH-1:0]     mul_b;
    logic [2*LENGTH-1:0]   mul_p;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*LENGTH-1:0]   out_p;

    // Environment side: operand source, multiplier and product sink
    modport master (
        output in_valid, in_a, in_b, mul_ready, mul_p, out_ready,
        input  in_ready, mul_start, mul_a, mul_b, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, mul_ready, mul_p, out_ready,
        output in_ready, mul_start, mul_a, mul_b, out_valid, out_p
    );
endinterface

// File: rtl/mult_op_fifo.sv
// Synchronous operand FIFO with occupancy count; head is read combinationally.
module mult_op_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mult_issue_ctrl.sv
// Feeds buffered operand pairs to the iterative multiplier and returns products downstream,
// with a watchdog that drops any operation the multiplier fails to finish.
module mult_issue_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned LENGTH  = DEF_LENGTH,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clock,
    input  logic                   reset,
    mult_issue_ctrl_if.slave       bus,
    output logic                   timeout_err,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int unsigned PW   = 2 * LENGTH;
    localparam int unsigned WD_W = $clog2(TIMEOUT) + 1;

    state_e            state;
    logic [WD_W-1:0]   wd_cnt;
    logic [PW-1:0]     head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;

    assign bus.in_ready = !reset && !fifo_full;
    assign fifo_push    = bus.in_valid && bus.in_ready;
    // Head leaves the FIFO on the edge that moves IDLE into ISSUE
    assign fifo_pop     = (state == ST_IDLE) && !fifo_empty && bus.mul_ready;

    mult_op_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({bus.in_a, bus.in_b}),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            wd_cnt        <= '0;
            bus.mul_start <= 1'b0;
            bus.mul_a     <= '0;
            bus.mul_b     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_p     <= '0;
            timeout_err   <= 1'b0;
        end else begin
            bus.mul_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        {bus.mul_a, bus.mul_b} <= head;
                        bus.mul_start          <= 1'b1;
                        state                  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    // A completing product wins over an expiring watchdog in the same cycle
                    if (state == ST_WAIT_DONE && bus.mul_ready) begin
                        bus.out_p     <= bus.mul_p;
                        bus.out_valid <= 1'b1;
                        state         <= ST_HOLD;
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                        if (state == ST_WAIT_BUSY && !bus.mul_ready) begin
                            state <= ST_WAIT_DONE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl with a behavioural iterative multiplier stand-in.
module tb_mult_issue_ctrl;
    localparam int unsigned LAT = 33;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       timeout_err;
    logic [2:0] fifo_count;
    logic       stub = 1'b0;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;

    mult_issue_ctrl_if #(.LENGTH(32)) bus ();

    mult_issue_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus.slave),
        .timeout_err (timeout_err),
        .fifo_count  (fifo_count)
    );

    always #5 clock = ~clock;

    // Multiplier stand-in: ready when idle, LAT cycles busy; stub freezes it mid-operation
    logic        mbusy;
    int unsigned mcnt;
    logic [31:0] ma, mb;
    always @(posedge clock) begin
        if (reset) begin
            mbusy         <= 1'b0;
            mcnt          <= 0;
            bus.mul_ready <= 1'b1;
            bus.mul_p     <= '0;
        end else if (!mbusy) begin
            if (bus.mul_start) begin
                mbusy         <= 1'b1;
                mcnt          <= 0;
                bus.mul_ready <= 1'b0;
                ma            <= bus.mul_a;
                mb            <= bus.mul_b;
            end
        end else if (!stub) begin
            if (mcnt == LAT - 1) begin
                bus.mul_p     <= 64'(ma) * 64'(mb);
                bus.mul_ready <= 1'b1;
                mbusy         <= 1'b0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    always @(posedge clock) if (bus.mul_start === 1'b1) start_cnt <= start_cnt + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%h exp=0x%h", name, got, exp);
        end
    endtask

    // Offers one pair at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [31:0] a, input logic [31:0] b, output int waited);
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        while (bus.in_ready !== 1'b1 && waited < 500) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 500) check("push_timeout", 64'(waited), 64'd0);
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [63:0] exp);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({name, "_p"}, bus.out_p, exp);
        @(negedge clock);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t        vecs [6];
    logic [63:0] burst_p [5];

    initial begin
        int w;
        int s0;
        int n;
        int bad;

        vecs[0] = '{32'h0000F0F0, 32'h0000FF00, 64'h00000000EFFF1000};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vecs[2] = '{32'h12345678, 32'h00000010, 64'h0000000123456780};
        vecs[3] = '{32'h80000000, 32'h00000002, 64'h0000000100000000};
        vecs[4] = '{32'hDEADBEEF, 32'h00000000, 64'h0000000000000000};
        vecs[5] = '{32'h00010001, 32'h00010001, 64'h0000000100020001};
        burst_p = '{64'h1000, 64'h1100, 64'h1200, 64'h1300, 64'h1400};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mul_start", 64'(bus.mul_start), 64'd0);
        check("rst_timeout", 64'(timeout_err), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_out_p", bus.out_p, 64'd0);
        check("rst_mul_ab", {bus.mul_a, bus.mul_b}, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Single operations with start-latency and single-pulse checks
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s0 = start_cnt;
            push(vecs[i].a, vecs[i].b, w);
            check($sformatf("v%0d_start_n", i), 64'(bus.mul_start), 64'd0);
            @(negedge clock);
            check($sformatf("v%0d_start_n1", i), 64'(bus.mul_start), 64'd1);
            check($sformatf("v%0d_mul_ab", i), {bus.mul_a, bus.mul_b}, {vecs[i].a, vecs[i].b});
            @(negedge clock);
            check($sformatf("v%0d_start_n2", i), 64'(bus.mul_start), 64'd0);
            wait_result($sformatf("v%0d", i), vecs[i].p);
            check($sformatf("v%0d_pulses", i), 64'(start_cnt - s0), 64'd1);
        end

        // Held result, then a five-deep burst behind it
        bus.out_ready = 1'b0;
        push(32'd3, 32'd5, w);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_p", bus.out_p, 64'd15);
        for (int i = 0; i < 4; i++) push(32'h10 + 32'(i), 32'h100, w);
        check("full_count", 64'(fifo_count), 64'd4);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        bad = 0;
        s0 = start_cnt;
        for (int i = 0; i < 200; i++) begin
            if (bus.out_valid !== 1'b1 || bus.out_p !== 64'd15 || bus.mul_start !== 1'b0) bad++;
            @(negedge clock);
        end
        check("hold_200_stable", 64'(bad), 64'd0);
        check("hold_200_no_start", 64'(start_cnt - s0), 64'd0);
        bus.out_ready = 1'b1;
        push(32'h14, 32'h100, w);
        check("fifth_wait", 64'(w), 64'd2);
        for (int i = 0; i < 5; i++) wait_result($sformatf("burst%0d", i), burst_p[i]);

        // Watchdog: frozen multiplier
        stub = 1'b1;
        push(32'd7, 32'd9, w);
        n = 0;
        while (bus.mul_start !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("wd_started", 64'(bus.mul_start), 64'd1);
        n = 0;
        while (timeout_err !== 1'b1 && n < 120) begin
            @(negedge clock);
            n++;
        end
        check("wd_flag", 64'(timeout_err), 64'd1);
        check("wd_window", 64'(n >= 63 && n <= 67), 64'd1);
        check("wd_no_valid", 64'(bus.out_valid), 64'd0);
        check("wd_out_p_kept", bus.out_p, 64'h1400);
        stub = 1'b0;
        push(32'h0000FFFF, 32'h0000FFFF, w);
        wait_result("after_wd", 64'h00000000FFFE0001);
        check("wd_sticky", 64'(timeout_err), 64'd1);

        // Reset during WAIT_DONE with a pair still queued
        push(32'd11, 32'd13, w);
        n = 0;
        while (bus.mul_start !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        repeat (10) @(negedge clock);
        push(32'd2, 32'd2, w);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_count", 64'(fifo_count), 64'd0);
        check("mid_rst_start", 64'(bus.mul_start), 64'd0);
        check("mid_rst_timeout", 64'(timeout_err), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_release", 64'(bus.in_ready), 64'd1);
        push(32'h100, 32'h100, w);
        wait_result("after_rst", 64'h10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
